ordered_dither: RTL
===================

# ordered_dither

- Reduces an 8-bit-per-channel RGB pixel stream to 4 bits per channel using a 4×4 Bayer ordered-dither matrix indexed by pixel position.
- Sits upstream of the grayscale stage and produces its R/G/B 4-bit inputs; the grayscale stage in turn feeds colour scramble.
- Pixel position comes from stream framing markers, not from timing counters.
- Two-stage pipeline, one pixel per clock, no backpressure.

## Interface
- `IN_W`, default 8: input channel width; must be ≥ 5.
- `OUT_W`, default 4: output channel width; fixed at 4.
- `CLK100MHZ`, input, 1: the block's single clock. All logic is on the rising edge.
- `CPU_RESETN`, input, 1: reset, asynchronous, active-low.
- `SW`, input, 1: dither enable. 1 = dither; 0 = plain truncation.
- `pix_valid_in`, input, 1: the input pixel is valid this cycle.
- `sof_in`, input, 1: start of frame. Qualified by `pix_valid_in`; marks pixel (0,0).
- `eol_in`, input, 1: last pixel of the line. Qualified by `pix_valid_in`.
- `R_in`, `G_in`, `B_in`, input, `IN_W` each: input colour channels.
- `pix_valid_out`, output, 1: output pixel valid.
- `sof_out`, output, 1: `sof_in` delayed to stay aligned with the output pixel.
- `eol_out`, output, 1: `eol_in` delayed to stay aligned with the output pixel.
- `R_grayscale`, `G_grayscale`, `B_grayscale`, output, 4 each: dithered channels, sent to the grayscale stage.

## Operation
- **Position counters:** `x_cnt[1:0]` and `y_cnt[1:0]`. They update only on cycles where `pix_valid_in` = 1.
- **Position used by the current pixel:**
  - If `sof_in` = 1: the pixel uses (0,0).
  - Otherwise: the pixel uses (`x_cnt`, `y_cnt`).
- **Counter update after a valid pixel:**
  - If `eol_in` = 1: x ← 0 and y ← (pixel's y + 1) mod 4.
  - Otherwise: x ← (pixel's x + 1) mod 4 and y is unchanged.
  - `sof_in` and `eol_in` on the same pixel: the pixel uses (0,0); afterwards x = 0, y = 1.
- **Bayer matrix** (row = y, column = x):
  - Row 0: 0 8 2 10
  - Row 1: 12 4 14 6
  - Row 2: 3 11 1 9
  - Row 3: 15 7 13 5
- **Per channel, with `SW` = 1:**
  - sum = in + th, computed at `IN_W`+1 bits.
  - q = sum >> (`IN_W` − 4).
  - out = 15 if q > 15, otherwise q[3:0]. This saturation is required.
- **Per channel, with `SW` = 0:** out = in[`IN_W`−1 : `IN_W`−4].
- **Threshold scaling:** th is the matrix value shifted left by (`IN_W` − 8) when `IN_W` > 8. For `IN_W` = 8 it is used as-is.
- **`SW` sampling:** `SW` is sampled in stage 1 together with the pixel. A change applies from the next accepted pixel; there is no glitch on pixels already in flight.
- **Invalid cycles:** they do not advance the counters. Pipeline registers still shift, carrying `pix_valid` = 0.
- **Stall-free pipeline:** no stall input; downstream must accept every valid output.

## Timing
- Pipeline stages:
  - Stage 1 registers the channels, the threshold, `SW`, `valid`, `sof` and `eol`.
  - Stage 2 registers the add/saturate result.
- Latency: a pixel presented at edge N appears on the outputs after edge N+2.
- Throughput: one pixel per cycle, sustained.
- Reset values (asynchronous on `CPU_RESETN` = 0):
  - All outputs are 0, including `pix_valid_out`, `sof_out` and `eol_out`.
  - `x_cnt`, `y_cnt` and the frame counter are 0.
  - Stage valids are cleared.
- Reset mid-frame: in-flight pixels are discarded and never emitted. After release, pixels before the next `sof_in` are dithered from position (0,0).
- Reset release is synchronous to `CLK100MHZ` in the system. The block adds no synchronizer.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- **Macro:** `ORDERED_DITHER_TEMPORAL_EN`.
- **Defined:**
  - A 2-bit frame counter `f` is added.
  - `f` increments on every valid `sof_in` pixel. It is incremented after that pixel's threshold is looked up, so the first frame after reset uses f = 0.
  - `f` wraps from 3 to 0.
  - Lookup index becomes ((x + f) mod 4, (y + f) mod 4). This rotates the pattern per frame to break static dither artefacts.
- **Undefined:** there is no frame counter, and the index is always (x, y).
- **Unaffected by the macro:** port list and latency.

## Test plan
1. Reset check: assert `CPU_RESETN` = 0 mid-stream with valid pixels in flight. Required: all outputs go to 0 immediately. After release, no stale pixel emerges; `pix_valid_out` stays 0 until 2 cycles after the next `pix_valid_in`.
2. Truncation: `SW` = 0, `R_in` = 0xAB, `G_in` = 0x10, `B_in` = 0xFF. Required: after 2 cycles, outputs A / 1 / F with `pix_valid_out` = 1.
3. Row 0 thresholds: `SW` = 1, `sof_in` on the first of 4 pixels, all channels 0x07. Required: outputs 0, 0, 0, 1 (thresholds 0, 8, 2, 10; 0x07 + 10 = 17 → 1).
4. Saturation: 0xFF at position (1,0). Required: 255 + 8 = 263, q = 16, output 15, not 0.
5. Line wrap and combined markers:
   - A 5-pixel line with `eol_in` on pixel 5; the next pixel is 0x05. Required: that pixel uses (0,1), th = 12, output 1.
   - A pixel with `sof_in` and `eol_in` both set. Required: the following pixel uses (0,1).
6. Temporal mode: `sof_in` pixel 0x0C in frame 0, then again in frame 1.
   - Macro defined: outputs 0 then 1 (th 0 then th 4).
   - Macro undefined: outputs 0 both times.
   - Both builds: latency 2.

Source files
------------

// File: rtl/ordered_dither_if.sv
// ordered_dither_if
// Pixel stream bundle between the upstream pixel source, the ordered dither
// block and the grayscale stage.
//   Input side  : pix_valid_in, sof_in, eol_in, R_in/G_in/B_in (IN_W bits)
//   Output side : pix_valid_out, sof_out, eol_out,
//                 R_grayscale/G_grayscale/B_grayscale (OUT_W bits)
// Modports:
//   slave  - the dither block (consumes the input side, drives the output side)
//   master - the environment (drives the input side, observes the output side)
interface ordered_dither_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
);
  logic             pix_valid_in;
  logic             sof_in;
  logic             eol_in;
  logic [IN_W-1:0]  R_in;
  logic [IN_W-1:0]  G_in;
  logic [IN_W-1:0]  B_in;

  logic             pix_valid_out;
  logic             sof_out;
  logic             eol_out;
  logic [OUT_W-1:0] R_grayscale;
  logic [OUT_W-1:0] G_grayscale;
  logic [OUT_W-1:0] B_grayscale;

  modport slave (
    input  pix_valid_in, sof_in, eol_in, R_in, G_in, B_in,
    output pix_valid_out, sof_out, eol_out, R_grayscale, G_grayscale, B_grayscale
  );

  modport master (
    output pix_valid_in, sof_in, eol_in, R_in, G_in, B_in,
    input  pix_valid_out, sof_out, eol_out, R_grayscale, G_grayscale, B_grayscale
  );
endinterface

// File: rtl/ordered_dither.sv
// ordered_dither
// Reduces an IN_W-bit-per-channel RGB stream to 4 bits per channel with a
// 4x4 Bayer ordered dither. The pixel position is recovered from the sof/eol
// framing markers. Two register stages, one pixel per clock, no backpressure.
// Ports:
//   CLK100MHZ  - clock, rising edge
//   CPU_RESETN - asynchronous active-low reset
//   SW         - 1 = dither, 0 = plain truncation (sampled with the pixel)
//   pix        - ordered_dither_if.slave pixel stream (in and out sides)
// Optional feature:
//   ORDERED_DITHER_TEMPORAL_EN - adds a 2-bit frame counter that rotates the
//   Bayer lookup index by the frame number to break static dither patterns.
module ordered_dither #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              SW,
  ordered_dither_if.slave   pix
);

  // Bayer thresholds are 0..15 at 8-bit scale; wider inputs shift them up.
  localparam int TH_SHIFT = (IN_W > 8) ? (IN_W - 8) : 0;
  localparam int Q_SHIFT  = IN_W - 4;

  logic [1:0] x_cnt, y_cnt;
  logic [1:0] pos_x, pos_y;
  logic [1:0] idx_x, idx_y;

  logic            s1_valid, s1_sof, s1_eol, s1_sw;
  logic [IN_W-1:0] s1_r, s1_g, s1_b;
  logic [3:0]      s1_th;

  // 4x4 Bayer matrix, row = y, column = x.
  function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
    logic [3:0] t;
    case ({y, x})
      4'h0: t = 4'd0;   4'h1: t = 4'd8;   4'h2: t = 4'd2;   4'h3: t = 4'd10;
      4'h4: t = 4'd12;  4'h5: t = 4'd4;   4'h6: t = 4'd14;  4'h7: t = 4'd6;
      4'h8: t = 4'd3;   4'h9: t = 4'd11;  4'hA: t = 4'd1;   4'hB: t = 4'd9;
      4'hC: t = 4'd15;  4'hD: t = 4'd7;   4'hE: t = 4'd13;  default: t = 4'd5;
    endcase
    return t;
  endfunction

  // One channel: add the scaled threshold with one bit of headroom, keep the
  // top four bits and saturate, so bright pixels clip to 15 instead of wrapping.
  function automatic logic [OUT_W-1:0] dither_ch(input logic [IN_W-1:0] v,
                                                 input logic [3:0] t,
                                                 input logic en);
    logic [IN_W:0] th_ext;
    logic [IN_W:0] sum;
    logic [IN_W:0] q;
    logic [OUT_W-1:0] res;
    th_ext = {{(IN_W-3){1'b0}}, t} << TH_SHIFT;
    sum    = {1'b0, v} + th_ext;
    q      = sum >> Q_SHIFT;
    if (!en)
      res = v[IN_W-1 -: 4];
    else if (|q[IN_W:4])
      res = '1;
    else
      res = q[3:0];
    return res;
  endfunction

  // A start-of-frame pixel is always (0,0), whatever the counters hold.
  always_comb begin
    pos_x = pix.sof_in ? 2'd0 : x_cnt;
    pos_y = pix.sof_in ? 2'd0 : y_cnt;
  end

`ifdef ORDERED_DITHER_TEMPORAL_EN
  logic [1:0] f_cnt;

  // Frame counter advances after the sof pixel has done its lookup.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)
      f_cnt <= 2'd0;
    else if (pix.pix_valid_in && pix.sof_in)
      f_cnt <= f_cnt + 2'd1;
  end

  always_comb begin
    idx_x = pos_x + f_cnt;
    idx_y = pos_y + f_cnt;
  end
`else
  always_comb begin
    idx_x = pos_x;
    idx_y = pos_y;
  end
`endif

  // Position tracking: only valid pixels move it; eol wraps to the next row.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      x_cnt <= 2'd0;
      y_cnt <= 2'd0;
    end else if (pix.pix_valid_in) begin
      if (pix.eol_in) begin
        x_cnt <= 2'd0;
        y_cnt <= pos_y + 2'd1;
      end else begin
        x_cnt <= pos_x + 2'd1;
        y_cnt <= pos_y;
      end
    end
  end

  // Stage 1: capture the pixel, its threshold, the mode and the markers.
  // Data shifts every cycle; invalid cycles simply carry valid = 0.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_sw    <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_th    <= 4'd0;
    end else begin
      s1_valid <= pix.pix_valid_in;
      s1_sof   <= pix.pix_valid_in & pix.sof_in;
      s1_eol   <= pix.pix_valid_in & pix.eol_in;
      s1_sw    <= SW;
      s1_r     <= pix.R_in;
      s1_g     <= pix.G_in;
      s1_b     <= pix.B_in;
      s1_th    <= bayer(idx_y, idx_x);
    end
  end

  // Stage 2: add/saturate and register every output.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pix.pix_valid_out <= 1'b0;
      pix.sof_out       <= 1'b0;
      pix.eol_out       <= 1'b0;
      pix.R_grayscale   <= '0;
      pix.G_grayscale   <= '0;
      pix.B_grayscale   <= '0;
    end else begin
      pix.pix_valid_out <= s1_valid;
      pix.sof_out       <= s1_sof;
      pix.eol_out       <= s1_eol;
      pix.R_grayscale   <= dither_ch(s1_r, s1_th, s1_sw);
      pix.G_grayscale   <= dither_ch(s1_g, s1_th, s1_sw);
      pix.B_grayscale   <= dither_ch(s1_b, s1_th, s1_sw);
    end
  end

endmodule
